// File: rtl/l1_dcache_pkg.sv
// Shared types for the L1 data cache: line/word types, FSM states and the byte-merge helper.
package l1_dcache_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [1:0]   lc3b_mem_wmask;
  typedef logic [127:0] lc3b_c_line;
  typedef logic [3:0]   lc3b_c_offset;

  localparam int unsigned WORDS_PER_LINE = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_ALLOCATE
  } cache_state_t;

  // Byte-granular write of one 16-bit word into a 128-bit line.
  function automatic lc3b_c_line merge_bytes(lc3b_c_line line, logic [2:0] word,
                                             lc3b_word wdata, lc3b_mem_wmask be);
    lc3b_c_line result;
    result = line;
    if (be[0]) result[{word, 4'd0} +: 8] = wdata[7:0];
    if (be[1]) result[{word, 4'd8} +: 8] = wdata[15:8];
    return result;
  endfunction

endpackage

// File: rtl/l1_dcache_if.sv
// CPU data port and physical-memory port of the L1 data cache, bundled as one interface.
interface l1_dcache_if;
  import l1_dcache_pkg::*;

  lc3b_word      mem_address;
  logic          mem_read;
  logic          mem_write;
  lc3b_mem_wmask mem_byte_enable;
  lc3b_word      mem_wdata;
  lc3b_word      mem_rdata;
  logic          mem_resp;

  lc3b_word      pmem_address;
  logic          pmem_read;
  logic          pmem_write;
  lc3b_c_line    pmem_wdata;
  lc3b_c_line    pmem_rdata;
  logic          pmem_resp;

  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp,
    output pmem_address, pmem_read, pmem_write, pmem_wdata
  );

  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp,
    input  pmem_address, pmem_read, pmem_write, pmem_wdata
  );

endinterface

// File: rtl/l1_dcache_control.sv
// Cache controller FSM: hit detection in IDLE, dirty-line writeback, then line fill.
module l1_dcache_control
  import l1_dcache_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic write_req,
  input  logic hit,
  input  logic line_dirty,
  input  logic pmem_resp,
  output logic mem_resp,
  output logic pmem_read,
  output logic pmem_write,
  output logic load_line,
  output logic load_tag,
  output logic set_dirty,
  output logic clr_dirty,
  output logic set_valid
);

  cache_state_t state, state_next;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // A request arriving while reset is asserted must not complete or mark the line dirty.
  always_comb begin
    state_next = state;
    mem_resp   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    load_line  = 1'b0;
    load_tag   = 1'b0;
    set_dirty  = 1'b0;
    clr_dirty  = 1'b0;
    set_valid  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req && !reset) begin
          if (hit) begin
            mem_resp  = 1'b1;
            set_dirty = write_req;
          end else if (line_dirty) begin
            state_next = S_WRITEBACK;
          end else begin
            state_next = S_ALLOCATE;
          end
        end
      end
      S_WRITEBACK: begin
        pmem_write = 1'b1;
        if (pmem_resp) begin
          clr_dirty  = 1'b1;
          state_next = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          load_line  = 1'b1;
          load_tag   = 1'b1;
          set_valid  = 1'b1;
          clr_dirty  = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache with 128-bit lines.
module l1_dcache
  import l1_dcache_pkg::*;
#(
  parameter int NUM_SETS = 8
) (
  input logic       clk,
  input logic       reset,
  l1_dcache_if.slave bus
);

  localparam int IDX   = $clog2(NUM_SETS);
  localparam int TAG_W = 16 - 4 - IDX;

  logic [IDX-1:0]   idx;
  logic [TAG_W-1:0] tag;
  logic [2:0]       word;
  logic             unused_addr_bit;

  lc3b_c_line       data_array [NUM_SETS];
  logic [TAG_W-1:0] tag_array  [NUM_SETS];
  logic [NUM_SETS-1:0] valid;
  logic [NUM_SETS-1:0] dirty;

  lc3b_c_line       cur_line;
  logic [TAG_W-1:0] cur_tag;
  logic             hit;

  logic load_line, load_tag, set_dirty, clr_dirty, set_valid;

  assign idx             = bus.mem_address[4 +: IDX];
  assign tag             = bus.mem_address[15 -: TAG_W];
  assign word            = bus.mem_address[3:1];
  assign unused_addr_bit = bus.mem_address[0];

  assign cur_line = data_array[idx];
  assign cur_tag  = tag_array[idx];
  assign hit      = valid[idx] && (cur_tag == tag);

  l1_dcache_control control (
    .clk        (clk),
    .reset      (reset),
    .req        (bus.mem_read | bus.mem_write),
    .write_req  (bus.mem_write),
    .hit        (hit),
    .line_dirty (dirty[idx]),
    .pmem_resp  (bus.pmem_resp),
    .mem_resp   (bus.mem_resp),
    .pmem_read  (bus.pmem_read),
    .pmem_write (bus.pmem_write),
    .load_line  (load_line),
    .load_tag   (load_tag),
    .set_dirty  (set_dirty),
    .clr_dirty  (clr_dirty),
    .set_valid  (set_valid)
  );

  // Data and tag storage carry no reset; validity alone decides whether contents are used.
  always_ff @(posedge clk) begin
    if (load_line)      data_array[idx] <= bus.pmem_rdata;
    else if (set_dirty) data_array[idx] <= merge_bytes(cur_line, word, bus.mem_wdata,
                                                       bus.mem_byte_enable);
    if (load_tag) tag_array[idx] <= tag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (set_valid) valid[idx] <= 1'b1;
      if (set_dirty)      dirty[idx] <= 1'b1;
      else if (clr_dirty) dirty[idx] <= 1'b0;
    end
  end

  // Writeback targets the resident line's address; fills target the requested one.
  assign bus.mem_rdata    = cur_line[{word, 4'd0} +: 16];
  assign bus.pmem_wdata   = cur_line;
  assign bus.pmem_address = bus.pmem_write ? {cur_tag, idx, 4'h0} : {tag, idx, 4'h0};

endmodule

// File: tb/tb_l1_dcache.sv
// Self-checking bench for l1_dcache: table of CPU accesses, scoreboarded read data, memory model.
module tb_l1_dcache;
  import l1_dcache_pkg::*;

  localparam int BUDGET = 200;

  typedef struct {
    lc3b_word      addr;
    logic          rd;
    logic          wr;
    lc3b_mem_wmask be;
    lc3b_word      wdata;
    int            lat;
  } vec_t;

  typedef struct {
    lc3b_word addr;
    lc3b_word exp;
  } sb_t;

  typedef struct {
    int         lat;
    logic       saw_wr;
    logic       saw_rd;
    logic       glitch;
    lc3b_word   wr_addr;
    lc3b_word   rd_addr;
    lc3b_c_line wr_line;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec  = 0;
  int   n_miss = 0;
  int   pmem_latency = 3;
  bit   pmem_hold = 1'b0;
  int   busy_cnt;

  lc3b_word   gold [lc3b_word];
  lc3b_c_line phys [lc3b_word];
  sb_t        sb_q [$];
  vec_t       vecs [$];

  always #5 clk = ~clk;

  l1_dcache_if bus ();

  l1_dcache #(.NUM_SETS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic lc3b_word init_word(lc3b_word a);
    if (a == 16'h1234) return 16'hBEEF;
    return a ^ 16'hC3A5;
  endfunction

  function automatic lc3b_word gold_rd(lc3b_word a);
    lc3b_word key;
    key = {a[15:1], 1'b0};
    if (gold.exists(key)) return gold[key];
    return init_word(key);
  endfunction

  function automatic void gold_wr(lc3b_word a, lc3b_mem_wmask be, lc3b_word d);
    lc3b_word w;
    w = gold_rd(a);
    if (be[0]) w[7:0]  = d[7:0];
    if (be[1]) w[15:8] = d[15:8];
    gold[{a[15:1], 1'b0}] = w;
  endfunction

  function automatic lc3b_c_line phys_line(lc3b_word base);
    lc3b_c_line l;
    if (phys.exists(base)) return phys[base];
    for (int w = 0; w < 8; w++) l[w*16 +: 16] = init_word(base + 16'(2*w));
    return l;
  endfunction

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Physical memory: answers a held strobe after pmem_latency cycles with a one-cycle pulse.
  initial begin
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      if (reset || pmem_hold || !(bus.pmem_read || bus.pmem_write)) begin
        busy_cnt = 0;
      end else begin
        busy_cnt++;
        if (busy_cnt >= pmem_latency) begin
          busy_cnt = 0;
          if (bus.pmem_write) phys[bus.pmem_address] = bus.pmem_wdata;
          else                bus.pmem_rdata = phys_line(bus.pmem_address);
          bus.pmem_resp = 1'b1;
        end
      end
    end
  end

  task automatic apply_stimulus(input lc3b_word addr, input logic rd, input logic wr,
                                input lc3b_mem_wmask be, input lc3b_word wdata, output obs_t o);
    sb_t  e;
    logic done;
    @(negedge clk);
    bus.mem_address     = addr;
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.mem_byte_enable = be;
    bus.mem_wdata       = wdata;
    e.addr = addr;
    e.exp  = gold_rd(addr);
    sb_q.push_back(e);
    if (wr) gold_wr(addr, be, wdata);
    o.lat = 0; o.saw_wr = 0; o.saw_rd = 0; o.glitch = 0;
    o.wr_addr = '0; o.rd_addr = '0; o.wr_line = '0;
    done = 1'b0;
    #1;
    while (!done && o.lat <= BUDGET) begin
      if (bus.pmem_read && bus.pmem_write) o.glitch = 1'b1;
      if (bus.mem_resp && (bus.pmem_read || bus.pmem_write)) o.glitch = 1'b1;
      if (bus.pmem_write && !o.saw_wr) begin
        o.saw_wr  = 1'b1;
        o.wr_addr = bus.pmem_address;
        o.wr_line = bus.pmem_wdata;
      end
      if (bus.pmem_read) begin
        if (!o.saw_rd) begin
          o.saw_rd  = 1'b1;
          o.rd_addr = bus.pmem_address;
        end else if (bus.pmem_address !== o.rd_addr) begin
          o.glitch = 1'b1;
        end
      end
      if (bus.mem_resp) begin
        done = 1'b1;
        if (sb_q.size() == 0) begin
          check_output("scoreboard_empty", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check_output($sformatf("rdata@%h", e.addr), bus.mem_rdata, e.exp);
        end
      end else begin
        @(negedge clk);
        #1;
        o.lat++;
      end
    end
    if (!done) begin
      check_output($sformatf("resp_timeout@%h", addr), 0, 1);
      if (sb_q.size() != 0) void'(sb_q.pop_front());
    end
    check_output("strobe_invariants", o.glitch, 0);
    @(negedge clk);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  initial begin
    obs_t o;
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    obs_t o;
    reset = 1'b1;
    bus.mem_address = '0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    bus.mem_byte_enable = '0; bus.mem_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check_output("reset_mem_resp", bus.mem_resp, 0);
    check_output("reset_pmem_read", bus.pmem_read, 0);
    check_output("reset_pmem_write", bus.pmem_write, 0);
    reset = 1'b0;

    // Cold read miss: fill from 0x1230, word2 preloaded with 0xBEEF.
    apply_stimulus(16'h1234, 1, 0, 2'b00, 16'h0000, o);
    check_output("t1_latency", o.lat, 4);
    check_output("t1_fill_addr", o.rd_addr, 16'h1230);
    check_output("t1_no_writeback", o.saw_wr, 0);

    vecs.push_back('{16'h1234, 1'b0, 1'b1, 2'b01, 16'hAB12, 0});
    vecs.push_back('{16'h1234, 1'b1, 1'b0, 2'b00, 16'h0000, 0});
    vecs.push_back('{16'h2050, 1'b1, 1'b0, 2'b00, 16'h0000, 4});
    vecs.push_back('{16'h2052, 1'b0, 1'b1, 2'b10, 16'h77AA, 0});
    vecs.push_back('{16'h2052, 1'b1, 1'b0, 2'b00, 16'h0000, 0});
    vecs.push_back('{16'h2054, 1'b0, 1'b1, 2'b00, 16'hFFFF, 0});
    vecs.push_back('{16'h2054, 1'b1, 1'b0, 2'b00, 16'h0000, 0});
    vecs.push_back('{16'h3000, 1'b0, 1'b1, 2'b11, 16'h1357, 4});
    vecs.push_back('{16'h3000, 1'b1, 1'b0, 2'b00, 16'h0000, 0});
    vecs.push_back('{16'h3002, 1'b1, 1'b1, 2'b11, 16'h2468, 0});
    vecs.push_back('{16'h3002, 1'b1, 1'b0, 2'b00, 16'h0000, 0});
    vecs.push_back('{16'h2A50, 1'b1, 1'b0, 2'b00, 16'h0000, 7});
    vecs.push_back('{16'h2052, 1'b1, 1'b0, 2'b00, 16'h0000, 4});
    vecs.push_back('{16'h3880, 1'b1, 1'b0, 2'b00, 16'h0000, 7});
    vecs.push_back('{16'h3002, 1'b1, 1'b0, 2'b00, 16'h0000, 4});

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].be, vecs[i].wdata, o);
      check_output($sformatf("vec%0d_latency", i), o.lat, vecs[i].lat);
      check_output($sformatf("vec%0d_pmem_traffic", i), o.saw_rd | o.saw_wr, vecs[i].lat != 0);
    end

    // Dirty conflict on set 3: writeback of the merged line, then fill of the new tag.
    apply_stimulus(16'h1A34, 1, 0, 2'b00, 16'h0000, o);
    check_output("t3_latency", o.lat, 7);
    check_output("t3_saw_writeback", o.saw_wr, 1);
    check_output("t3_wb_addr", o.wr_addr, 16'h1230);
    check_output("t3_wb_word2", o.wr_line[47:32], 16'hBE12);
    check_output("t3_fill_addr", o.rd_addr, 16'h1A30);

    apply_stimulus(16'h1B34, 1, 0, 2'b00, 16'h0000, o);
    check_output("t4_latency", o.lat, 4);
    check_output("t4_no_writeback", o.saw_wr, 0);
    check_output("t4_fill_addr", o.rd_addr, 16'h1B30);

    // Slow fill: pmem_read and address must hold steady while waiting.
    pmem_latency = 12;
    apply_stimulus(16'h4070, 1, 0, 2'b00, 16'h0000, o);
    check_output("t5_latency", o.lat, 13);
    check_output("t5_fill_addr", o.rd_addr, 16'h4070);
    pmem_latency = 3;

    // Reset in the middle of a fill abandons it.
    pmem_hold = 1'b1;
    @(negedge clk);
    bus.mem_address = 16'h5060;
    bus.mem_read    = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_output("t6_alloc_pmem_read", bus.pmem_read, 1);
    reset = 1'b1;
    bus.mem_read = 1'b0;
    @(negedge clk);
    #1;
    check_output("t6_post_reset_pmem_read", bus.pmem_read, 0);
    check_output("t6_post_reset_pmem_write", bus.pmem_write, 0);
    check_output("t6_post_reset_mem_resp", bus.mem_resp, 0);
    reset = 1'b0;
    pmem_hold = 1'b0;

    apply_stimulus(16'h5060, 1, 0, 2'b00, 16'h0000, o);
    check_output("t6_reread_latency", o.lat, 4);
    check_output("t6_reread_fill", o.saw_rd, 1);
    apply_stimulus(16'h3002, 1, 0, 2'b00, 16'h0000, o);
    check_output("t6_after_reset_latency", o.lat, 4);
    apply_stimulus(16'h5062, 1, 1, 2'b01, 16'h00C3, o);
    check_output("t6_rdwr_latency", o.lat, 0);
    apply_stimulus(16'h5062, 1, 0, 2'b00, 16'h0000, o);
    check_output("t6_rdwr_readback_latency", o.lat, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
